// File: rtl/encoder_pkg.sv
// Shared types and default widths for the encoder PWM position reader.
//   enc_pwm_state_t : acquisition FSM states
//   K_ENC_POS_W     : default position result width
//   K_ENC_CNT_W     : default high-time / period counter width
package encoder_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ARM,
      HIGH,
      LOW,
      DIV,
      DONE
   } enc_pwm_state_t;

   localparam int unsigned K_ENC_POS_W = 12;
   localparam int unsigned K_ENC_CNT_W = 16;

endpackage

// File: rtl/pwm_ratio_div.sv
// Restoring divider producing Q_W quotient bits, one bit per clock.
// The caller guarantees i_num >> Q_W < i_den, so the quotient fits in Q_W bits
// and NUM_W == DEN_W + Q_W. Remainder is discarded.
// Ports:
//   i_clk, i_rst_n : clock, synchronous active-low reset
//   i_abort        : drop any division in flight
//   i_start        : load operands (ignored while busy)
//   i_num, i_den   : dividend, divisor
//   o_busy         : iterations in progress
//   o_done         : one-cycle pulse, o_q valid from this cycle until the next start
//   o_q            : quotient
module pwm_ratio_div #(
   parameter int unsigned NUM_W = 28,
   parameter int unsigned DEN_W = 16,
   parameter int unsigned Q_W   = 12
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_abort,
   input  logic             i_start,
   input  logic [NUM_W-1:0] i_num,
   input  logic [DEN_W-1:0] i_den,
   output logic             o_busy,
   output logic             o_done,
   output logic [Q_W-1:0]   o_q
);

   localparam int unsigned CW = $clog2(Q_W + 1);

   logic [DEN_W-1:0] rem_q;
   logic [DEN_W-1:0] den_q;
   logic [Q_W-1:0]   lo_q;
   logic [Q_W-1:0]   q_q;
   logic [CW-1:0]    cnt_q;
   logic             busy_q;
   logic             done_q;

   logic [DEN_W:0]   trial;
   logic             fit;
   logic [DEN_W-1:0] rem_next;

   // Partial remainder stays below the divisor, so it always fits DEN_W bits.
   always_comb begin
      trial    = {rem_q, lo_q[Q_W-1]};
      fit      = (trial >= {1'b0, den_q});
      rem_next = fit ? DEN_W'(trial - {1'b0, den_q}) : trial[DEN_W-1:0];
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n || i_abort) begin
         rem_q  <= '0;
         den_q  <= '0;
         lo_q   <= '0;
         q_q    <= '0;
         cnt_q  <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (i_start && !busy_q) begin
            rem_q  <= i_num[NUM_W-1 -: DEN_W];
            lo_q   <= i_num[Q_W-1:0];
            den_q  <= i_den;
            q_q    <= '0;
            cnt_q  <= CW'(Q_W);
            busy_q <= 1'b1;
         end else if (busy_q) begin
            rem_q <= rem_next;
            lo_q  <= lo_q << 1;
            q_q   <= {q_q[Q_W-2:0], fit};
            cnt_q <= cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               busy_q <= 1'b0;
               done_q <= 1'b1;
            end
         end
      end
   end

   assign o_busy = busy_q;
   assign o_done = done_q;
   assign o_q    = q_q;

endmodule

// File: rtl/encoder_pwm_decoder.sv
// PWM-position reader for absolute magnetic encoders.
// Measures high time H and period P of i_pwm in clock cycles and reports
// position = floor((H << POS_W) / P), in one-shot or continuous acquisition.
// Ports:
//   i_clk, i_rst_n   : clock, synchronous active-low reset
//   i_pwm            : asynchronous encoder PWM input
//   i_start          : pulse, begin acquisition (only honoured in IDLE/DONE)
//   i_continuous     : sampled at i_start, 1 = free-running
//   i_clear          : pulse, abort and clear everything back to IDLE
//   o_enc_pos        : latest position
//   o_period         : P of the frame that produced o_enc_pos
//   o_valid          : o_enc_pos valid (sticky)
//   o_busy           : acquisition or division in progress
//   o_timeout        : sticky, expected edge never arrived
//   o_overrun        : sticky, a frame closed while the divider was busy
module encoder_pwm_decoder
   import encoder_pkg::*;
#(
   parameter int unsigned POS_W       = K_ENC_POS_W,
   parameter int unsigned CNT_W       = K_ENC_CNT_W,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_pwm,
   input  logic             i_start,
   input  logic             i_continuous,
   input  logic             i_clear,
   output logic [POS_W-1:0] o_enc_pos,
   output logic [CNT_W-1:0] o_period,
   output logic             o_valid,
   output logic             o_busy,
   output logic             o_timeout,
   output logic             o_overrun
);

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == '1) ? v : v + CNT_W'(1);
   endfunction

   // Input synchroniser and registered edge detect
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;
   logic                   rise_q;
   logic                   fall_q;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         sync_q <= '0;
         prev_q <= 1'b0;
         rise_q <= 1'b0;
         fall_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], i_pwm};
         prev_q <= sync_q[SYNC_STAGES-1];
         rise_q <= sync_q[SYNC_STAGES-1] & ~prev_q;
         fall_q <= ~sync_q[SYNC_STAGES-1] & prev_q;
      end
   end

   enc_pwm_state_t   state_q;
   logic             cont_q;
   logic [CNT_W-1:0] h_cnt_q;
   logic [CNT_W-1:0] p_cnt_q;
   logic [CNT_W-1:0] h_lat_q;
   logic [CNT_W-1:0] p_lat_q;
   logic [POS_W-1:0] pos_q;
   logic [CNT_W-1:0] period_q;
   logic             valid_q;
   logic             timeout_q;
   logic             overrun_q;

   logic             timeout_hit;
   logic             close;
   logic             div_start;
   logic [CNT_W-1:0] p_meas;
   logic             div_busy;
   logic             div_done;
   logic [POS_W-1:0] div_q;

   always_comb begin
      timeout_hit = (state_q inside {ARM, HIGH, LOW}) && (p_cnt_q == '1);
      close       = (state_q == LOW) && rise_q && !timeout_hit;
      div_start   = close && !div_busy && !i_clear;
      p_meas      = sat_inc(p_cnt_q);
   end

   pwm_ratio_div #(
      .NUM_W (CNT_W + POS_W),
      .DEN_W (CNT_W),
      .Q_W   (POS_W)
   ) u_div (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_abort (i_clear),
      .i_start (div_start),
      .i_num   ({h_lat_q, {POS_W{1'b0}}}),
      .i_den   (p_meas),
      .o_busy  (div_busy),
      .o_done  (div_done),
      .o_q     (div_q)
   );

   always_ff @(posedge i_clk) begin
      if (!i_rst_n || i_clear) begin
         state_q   <= IDLE;
         cont_q    <= 1'b0;
         h_cnt_q   <= '0;
         p_cnt_q   <= '0;
         h_lat_q   <= '0;
         p_lat_q   <= '0;
         pos_q     <= '0;
         period_q  <= '0;
         valid_q   <= 1'b0;
         timeout_q <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         // A division finishing is captured regardless of what the FSM is doing,
         // which is how continuous mode overlaps measurement with division.
         if (div_done) begin
            pos_q    <= div_q;
            period_q <= p_lat_q;
            valid_q  <= 1'b1;
         end
         if (timeout_hit) begin
            timeout_q <= 1'b1;
            h_cnt_q   <= '0;
            p_cnt_q   <= '0;
            state_q   <= cont_q ? ARM : DONE;
         end else begin
            case (state_q)
               IDLE, DONE: begin
                  if (i_start) begin
                     state_q   <= ARM;
                     cont_q    <= i_continuous;
                     valid_q   <= 1'b0;
                     timeout_q <= 1'b0;
                     overrun_q <= 1'b0;
                     h_cnt_q   <= '0;
                     p_cnt_q   <= '0;
                  end
               end
               ARM: begin
                  if (rise_q) begin
                     state_q <= HIGH;
                     h_cnt_q <= '0;
                     p_cnt_q <= '0;
                  end else begin
                     p_cnt_q <= sat_inc(p_cnt_q);
                  end
               end
               HIGH: begin
                  h_cnt_q <= sat_inc(h_cnt_q);
                  p_cnt_q <= sat_inc(p_cnt_q);
                  if (fall_q) begin
                     h_lat_q <= sat_inc(h_cnt_q);
                     state_q <= LOW;
                  end
               end
               LOW: begin
                  if (rise_q) begin
                     // Busy divider: drop this frame, let the running one finish.
                     if (div_busy) overrun_q <= 1'b1;
                     else          p_lat_q   <= p_meas;
                     h_cnt_q <= '0;
                     p_cnt_q <= '0;
                     state_q <= cont_q ? HIGH : DIV;
                  end else begin
                     p_cnt_q <= sat_inc(p_cnt_q);
                  end
               end
               DIV: begin
                  if (div_done) state_q <= DONE;
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   assign o_enc_pos = pos_q;
   assign o_period  = period_q;
   assign o_valid   = valid_q;
   assign o_busy    = !(state_q inside {IDLE, DONE}) || div_busy;
   assign o_timeout = timeout_q;
   assign o_overrun = overrun_q;

endmodule

// File: tb/tb_encoder_pwm_decoder.sv
// Bench for encoder_pwm_decoder: directed PWM frames, expected results queued
// ahead of stimulus and consumed by an independent output monitor.
module tb_encoder_pwm_decoder;

   localparam int unsigned POS_W = 12;
   localparam int unsigned CNT_W = 16;
   localparam int unsigned SYNC  = 2;
   // pin edge -> rise pulse (SYNC+1 edges) -> o_valid (POS_W+2 edges)
   localparam int unsigned LAT   = SYNC + 1 + POS_W + 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic             rst_n, pwm, start, cont, clr;
   logic [POS_W-1:0] enc_pos;
   logic [CNT_W-1:0] period;
   logic             valid, busy, tmo, ovr;

   logic             pwm_b, start_b;
   logic [POS_W-1:0] enc_pos_b;
   logic [9:0]       period_b;
   logic             valid_b, busy_b, tmo_b, ovr_b;

   encoder_pwm_decoder #(.POS_W(POS_W), .CNT_W(CNT_W), .SYNC_STAGES(SYNC)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_pwm(pwm), .i_start(start), .i_continuous(cont),
      .i_clear(clr), .o_enc_pos(enc_pos), .o_period(period), .o_valid(valid),
      .o_busy(busy), .o_timeout(tmo), .o_overrun(ovr)
   );

   encoder_pwm_decoder #(.POS_W(POS_W), .CNT_W(10), .SYNC_STAGES(SYNC)) dut_b (
      .i_clk(clk), .i_rst_n(rst_n), .i_pwm(pwm_b), .i_start(start_b), .i_continuous(1'b0),
      .i_clear(1'b0), .o_enc_pos(enc_pos_b), .o_period(period_b), .o_valid(valid_b),
      .o_busy(busy_b), .o_timeout(tmo_b), .o_overrun(ovr_b)
   );

   typedef struct {
      logic [31:0] pos;
      logic [31:0] per;
   } exp_t;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic pwm_frame(input int h, input int p);
      pwm = 1'b1;
      tick(h);
      pwm = 1'b0;
      tick(p - h);
   endtask

   task automatic expect_res(input int pos, input int per);
      exp_t e;
      e.pos = pos;
      e.per = per;
      sb.push_back(e);
   endtask

   task automatic go(input logic c);
      cont  = c;
      start = 1'b1;
      tick(1);
      start = 1'b0;
   endtask

   task automatic pulse_clear();
      clr = 1'b1;
      tick(1);
      clr = 1'b0;
   endtask

   // Monitor: a new result is o_valid rising or a change of the reported values.
   initial begin
      logic             pv;
      logic [POS_W-1:0] ppos;
      logic [CNT_W-1:0] pper;
      exp_t             e;
      pv   = 1'b0;
      ppos = '0;
      pper = '0;
      forever begin
         @(negedge clk);
         if (valid && (!pv || enc_pos != ppos || period != pper)) begin
            if (sb.size() == 0) begin
               check("unexpected_result", 32'(enc_pos), 32'hFFFF_FFFF);
            end else begin
               e = sb.pop_front();
               check("result_pos", 32'(enc_pos), e.pos);
               check("result_period", 32'(period), e.per);
            end
         end
         pv   = valid;
         ppos = enc_pos;
         pper = period;
      end
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n;
      rst_n = 1'b0; pwm = 1'b0; start = 1'b0; cont = 1'b0; clr = 1'b0;
      pwm_b = 1'b0; start_b = 1'b0;
      tick(3);
      check("rst_pos", 32'(enc_pos), 0);
      check("rst_period", 32'(period), 0);
      check("rst_valid", 32'(valid), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_timeout", 32'(tmo), 0);
      check("rst_overrun", 32'(ovr), 0);
      rst_n = 1'b1;
      tick(2);

      // 1. one-shot H=250 P=1000 -> 1024
      go(1'b0);
      expect_res(1024, 1000);
      pwm_frame(250, 1000);
      pwm = 1'b1;
      n = 0;
      while (!valid && n < 40) begin
         tick(1);
         n++;
      end
      check("t1_latency", 32'(n), LAT);
      check("t1_busy", 32'(busy), 0);
      pwm = 1'b0;
      tick(5);

      // 2. continuous H=500, 750, 750 at P=1000 -> 2048, 3072
      go(1'b1);
      expect_res(2048, 1000);
      expect_res(3072, 1000);
      pwm_frame(500, 1000);
      pwm_frame(750, 1000);
      pwm_frame(750, 1000);
      pwm = 1'b1;
      tick(30);
      check("t2_valid", 32'(valid), 1);
      check("t2_overrun", 32'(ovr), 0);
      check("t2_drained", 32'(sb.size()), 0);
      pulse_clear();
      pwm = 1'b0;
      tick(5);

      // 3. CNT_W=10 instance, pin stuck low: timeout after 1023 cycles in ARM
      start_b = 1'b1;
      tick(1);
      start_b = 1'b0;
      tick(1023);
      check("t3_timeout_early", 32'(tmo_b), 0);
      tick(1);
      check("t3_timeout", 32'(tmo_b), 1);
      check("t3_valid", 32'(valid_b), 0);
      check("t3_busy", 32'(busy_b), 0);

      // 4. continuous P=8: every other frame dropped, H=1,3,5 survive
      go(1'b1);
      expect_res(512, 8);
      expect_res(1536, 8);
      expect_res(2560, 8);
      for (int h = 1; h <= 6; h++) pwm_frame(h, 8);
      pwm = 1'b1;
      tick(30);
      check("t4_overrun", 32'(ovr), 1);
      check("t4_valid", 32'(valid), 1);
      check("t4_drained", 32'(sb.size()), 0);
      pulse_clear();
      pwm = 1'b0;
      tick(5);

      // 5. clear and start together during LOW
      go(1'b1);
      expect_res(2048, 1000);
      pwm_frame(500, 1000);
      pwm = 1'b1;
      tick(500);
      pwm = 1'b0;
      tick(100);
      check("t5_pre_valid", 32'(valid), 1);
      clr   = 1'b1;
      start = 1'b1;
      tick(1);
      clr   = 1'b0;
      start = 1'b0;
      check("t5_valid", 32'(valid), 0);
      check("t5_timeout", 32'(tmo), 0);
      check("t5_overrun", 32'(ovr), 0);
      check("t5_pos", 32'(enc_pos), 0);
      check("t5_period", 32'(period), 0);
      tick(3);
      check("t5_busy", 32'(busy), 0);

      // 6. reset during DIV, then one-shot H=1 P=4096 -> 1
      go(1'b0);
      pwm_frame(100, 200);
      pwm = 1'b1;
      tick(8);
      check("t6_pre_busy", 32'(busy), 1);
      rst_n = 1'b0;
      tick(1);
      check("t6_pos", 32'(enc_pos), 0);
      check("t6_period", 32'(period), 0);
      check("t6_valid", 32'(valid), 0);
      check("t6_busy", 32'(busy), 0);
      check("t6_timeout", 32'(tmo), 0);
      check("t6_overrun", 32'(ovr), 0);
      rst_n = 1'b1;
      pwm   = 1'b0;
      tick(5);
      go(1'b0);
      expect_res(1, 4096);
      pwm_frame(1, 4096);
      pwm = 1'b1;
      n = 0;
      while (!valid && n < 40) begin
         tick(1);
         n++;
      end
      check("t6_latency", 32'(n), LAT);
      pwm = 1'b0;
      tick(5);
      check("final_drained", 32'(sb.size()), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
